// File: rtl/inst_encoder_pkg.sv
// inst_encoder_pkg: mode codes, opcode constants, request record and sign-extension helper
package inst_encoder_pkg;
  typedef enum logic [2:0] {
    MODE_R     = 3'd0,
    MODE_I     = 3'd1,
    MODE_SHAMT = 3'd2,
    MODE_U     = 3'd3,
    MODE_J     = 3'd4,
    MODE_B     = 3'd5,
    MODE_S     = 3'd6,
    MODE_ILL   = 3'd7
  } mode_e;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_STORE  = 7'h23;
  typedef struct packed {
    logic [2:0]  mode;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } req_t;
  function automatic logic sext_fits(input logic [31:0] v, input int unsigned b);
    logic [31:0] t;
    t = $signed(v) >>> b;
    return (t == '0) || (t == '1);
  endfunction
endpackage

// File: rtl/inst_encoder_imm_pack.sv
// imm_pack: packs fields and immediate into an instruction word by mode and flags range/mode errors
module imm_pack
  import inst_encoder_pkg::*;
(
  input  logic [2:0]  mode,
  input  logic [31:0] imm,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic [31:0] inst,
  output logic        err
);
  always_comb begin
    inst = '0;
    err  = 1'b0;
    case (mode_e'(mode))
      MODE_R: inst = {funct7, rs2, rs1, funct3, rd, opcode};
      MODE_I: begin
        inst = {imm[11:0], rs1, funct3, rd, opcode};
        err  = !sext_fits(imm, 11);
      end
      MODE_SHAMT: begin
        inst = {funct7, imm[4:0], rs1, funct3, rd, opcode};
        err  = |imm[31:5];
      end
      MODE_U: begin
        inst = {imm[31:12], rd, opcode};
        err  = |imm[11:0];
      end
      MODE_J: begin
        inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        err  = !sext_fits(imm, 20) || imm[0];
      end
      MODE_B: begin
        inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        err  = !sext_fits(imm, 12) || imm[0];
      end
      MODE_S: begin
        inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        err  = !sext_fits(imm, 11);
      end
      default: err = 1'b1;
    endcase
  end
endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: two-stage valid/ready instruction encoder with range checking and saturating error count
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           mode,
  input  logic [31:0]          imm,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic [4:0]           rd,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          inst,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);
  req_t        s1;
  logic        s1_valid, s2_valid, s1_load, s2_load, pk_err;
  logic [31:0] pk_inst;
  assign s2_load   = !s2_valid || out_ready;
  assign s1_load   = !s1_valid || s2_load;
  assign in_ready  = !rst && s1_load;
  assign out_valid = s2_valid;
  imm_pack u_pack (
    .mode   (s1.mode),
    .imm    (s1.imm),
    .opcode (s1.opcode),
    .funct3 (s1.funct3),
    .funct7 (s1.funct7),
    .rd     (s1.rd),
    .rs1    (s1.rs1),
    .rs2    (s1.rs2),
    .inst   (pk_inst),
    .err    (pk_err)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= '0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      inst     <= '0;
      err      <= 1'b0;
      err_cnt  <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= in_valid;
        if (in_valid) s1 <= {mode, imm, opcode, funct3, funct7, rd, rs1, rs2};
      end
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          inst <= pk_inst;
          err  <= pk_err;
        end
      end
      if (s2_valid && out_ready && err && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: directed scoreboard bench for inst_encoder
module tb_inst_encoder;
  import inst_encoder_pkg::*;
  logic        clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic        in_ready, out_valid, err;
  logic [2:0]  mode = 0, funct3 = 0;
  logic [31:0] imm = 0, inst;
  logic [6:0]  opcode = 0, funct7 = 0;
  logic [4:0]  rd = 0, rs1 = 0, rs2 = 0;
  logic [15:0] err_cnt;
  int          checks = 0, errors = 0;
  logic [32:0] sb[$];
  logic [32:0] exp_v;
  logic [15:0] model_cnt = 0;
  logic        pv = 0, pr = 0, pe = 0, last_err = 0;
  logic [31:0] pi = 0, last_inst = 0;

  always #5 clk = ~clk;

  inst_encoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode), .imm(imm),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2),
    .out_valid(out_valid), .out_ready(out_ready), .inst(inst), .err(err), .err_cnt(err_cnt)
  );

  function automatic logic [32:0] model(input logic [2:0] m, input logic [31:0] im, input logic [6:0] op,
                                        input logic [2:0] f3, input logic [6:0] f7,
                                        input logic [4:0] d, input logic [4:0] r1, input logic [4:0] r2);
    logic [31:0] i;
    logic        e;
    i = 0;
    e = 0;
    case (m)
      3'd0: i = {f7, r2, r1, f3, d, op};
      3'd1: begin i = {im[11:0], r1, f3, d, op}; e = im != {{20{im[11]}}, im[11:0]}; end
      3'd2: begin i = {f7, im[4:0], r1, f3, d, op}; e = im[31:5] != 0; end
      3'd3: begin i = {im[31:12], d, op}; e = im[11:0] != 0; end
      3'd4: begin i = {im[20], im[10:1], im[11], im[19:12], d, op}; e = (im != {{11{im[20]}}, im[20:0]}) || im[0]; end
      3'd5: begin i = {im[12], im[10:5], r2, r1, f3, im[4:1], im[11], op}; e = (im != {{19{im[12]}}, im[12:0]}) || im[0]; end
      3'd6: begin i = {im[11:5], r2, r1, f3, im[4:0], op}; e = im != {{20{im[11]}}, im[11:0]}; end
      default: begin i = 0; e = 1; end
    endcase
    return {e, i};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      model_cnt = 0;
      pv = 0;
    end else begin
      if (pv && !pr) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_inst", inst, pi);
        chk("hold_err", err, pe);
      end
      if (out_valid && out_ready) begin
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          exp_v = sb.pop_front();
          chk("inst", inst, exp_v[31:0]);
          chk("err", err, exp_v[32]);
          chk("err_cnt", err_cnt, model_cnt);
          if (exp_v[32] && model_cnt != 16'hFFFF) model_cnt++;
        end
        last_inst = inst;
        last_err  = err;
      end
      if (in_valid && in_ready) sb.push_back(model(mode, imm, opcode, funct3, funct7, rd, rs1, rs2));
      pv = out_valid;
      pr = out_ready;
      pi = inst;
      pe = err;
    end
  end

  task automatic drive(input logic [2:0] m, input logic [31:0] im, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [4:0] d, input logic [4:0] r1, input logic [4:0] r2);
    in_valid = 1; mode = m; imm = im; opcode = op; funct3 = f3; funct7 = f7; rd = d; rs1 = r1; rs2 = r2;
  endtask

  task automatic wait_acc();
    int   n;
    logic acc;
    n = 0;
    acc = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 40);
    chk("accepted", acc, 1);
    in_valid = 0;
  endtask

  task automatic send(input logic [2:0] m, input logic [31:0] im, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [4:0] d, input logic [4:0] r1, input logic [4:0] r2);
    drive(m, im, op, f3, f7, d, r1, r2);
    wait_acc();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drained", sb.size() == 0 && !out_valid, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_err", err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    rst = 0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    send(MODE_I, 32'hFFFFFFFF, OP_IMM, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("lat_cycle1", out_valid, 0);
    @(negedge clk);
    chk("lat_cycle2", out_valid, 1);
    drain();
    chk("I_inst", last_inst, 32'hFFF00093);
    chk("I_err", last_err, 0);
    send(MODE_U, 32'h12345000, OP_LUI, 0, 0, 5, 0, 0);
    drain();
    chk("U_inst", last_inst, 32'h123452B7);
    chk("U_err", last_err, 0);
    send(MODE_U, 32'h12345001, OP_LUI, 0, 0, 5, 0, 0);
    drain();
    chk("U_bad_err", last_err, 1);
    chk("U_bad_cnt", err_cnt, 1);
    send(MODE_J, 32'd8, OP_JAL, 0, 0, 1, 0, 0);
    drain();
    chk("J_inst", last_inst, 32'h008000EF);
    send(MODE_B, 32'hFFFFFFFC, OP_BRANCH, 0, 0, 0, 0, 0);
    drain();
    chk("B_inst", last_inst, 32'hFE000EE3);
    chk("B_err", last_err, 0);
    for (int i = 0; i < 16; i++)
      send(3'($urandom_range(0, 7)), i[0] ? $urandom : 32'($urandom_range(0, 4095)), 7'($urandom),
           3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
    drain();
    out_ready = 0;
    send(MODE_R, 0, OP_REG, 3'd1, 7'h20, 5'd3, 5'd4, 5'd5);
    send(MODE_S, 32'hFFFFFFF8, OP_STORE, 3'd2, 0, 0, 5'd6, 5'd7);
    drive(MODE_I, 32'd5, OP_IMM, 0, 0, 5'd8, 5'd9, 0);
    @(negedge clk);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_accepted", sb.size(), 2);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_still_blocked", in_ready, 0);
    out_ready = 1;
    wait_acc();
    drain();
    chk("bp_last_inst", last_inst, 32'h00548413);
    send(MODE_I, 32'd2048, OP_IMM, 0, 0, 1, 0, 0);
    drain();
    chk("I_range_err", last_err, 1);
    send(MODE_ILL, 32'h12345678, OP_IMM, 3'd7, 7'h7F, 5'd31, 5'd31, 5'd31);
    drain();
    chk("ill_inst", last_inst, 0);
    chk("ill_err", last_err, 1);
    force dut.err_cnt = 16'hFFFD;
    model_cnt = 16'hFFFD;
    @(negedge clk);
    release dut.err_cnt;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) send(MODE_ILL, 0, 0, 0, 0, 0, 0, 0);
    drain();
    chk("sat_cnt", err_cnt, 16'hFFFF);
    out_ready = 0;
    send(MODE_R, 0, OP_REG, 0, 0, 1, 2, 3);
    send(MODE_ILL, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("full_out_valid", out_valid, 1);
    @(posedge clk);
    #1;
    rst = 1;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_err_cnt", err_cnt, 0);
    chk("midrst_inst", inst, 0);
    rst = 0;
    out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_stale", out_valid, 0);
    end
    @(posedge clk);
    #1;
    send(MODE_SHAMT, 32'd7, OP_IMM, 3'd5, 7'h20, 5'd2, 5'd3, 0);
    drain();
    chk("shamt_inst", last_inst, 32'h4071D113);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 The block SHALL have the following parameter: ERR_CNT_W, default 16, width of the saturating error counter.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- mode  in  3  immediate format: 0 R (no imm), 1 I, 2 shamt, 3 U, 4 J, 5 B, 6 S, 7 illegal.
- imm  in  32  full-width immediate value to pack.
- opcode  in  7  opcode field.
- funct3  in  3  funct3 field.
- funct7  in  7  funct7 field.
- rd, rs1, rs2  in  5 each  register fields.
- out_valid  out  1  encoded instruction valid.
- out_ready  in  1  consumer accepts the instruction.
- inst  out  32  encoded instruction.
- err  out  1  range or mode error for the current inst.
- err_cnt  out  ERR_CNT_W  saturating count of errored instructions delivered.

Function
REQ-003 A transfer SHALL occur on any clk edge with valid and ready both high, on each side independently.
REQ-004 The datapath SHALL have two register stages: S1 captures the request and computes the range check; S2 holds the packed inst and err.
- Latency: 2 cycles from input transfer to out_valid when unstalled.
- Throughput: 1 per cycle.
REQ-005 Stage advance: S2 SHALL load when it is empty or out_ready is high; S1 SHALL load when it is empty or S2 loads.
- in_ready = !S1.valid || S2 loads (combinational, no skid).
REQ-006 Under backpressure, capacity SHALL be 2 requests, with no loss, duplication or reordering; out_valid, inst and err SHALL hold stable while out_valid is high and out_ready is low.
REQ-007 Packing by mode:
- R: {funct7, rs2, rs1, funct3, rd, opcode}.
- I: {imm[11:0], rs1, funct3, rd, opcode}.
- shamt: {funct7, imm[4:0], rs1, funct3, rd, opcode}.
- U: {imm[31:12], rd, opcode}.
- J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
- B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
- S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
REQ-008 Range checks (err=1 when violated):
- I and S: imm is the sign-extension of imm[11:0].
- shamt: imm[31:5] == 0.
- U: imm[11:0] == 0.
- J: imm is the sign-extension of imm[20:0] and imm[0] == 0.
- B: imm is the sign-extension of imm[12:0] and imm[0] == 0.
- R: never errs.
REQ-009 On a range error, inst SHALL still carry the truncated packing per REQ-007.
REQ-010 mode 7 SHALL produce err=1 and inst=0.
REQ-011 err_cnt SHALL increment by 1 on each output transfer with err=1 and saturate at all-ones (no wrap).

Reset
REQ-012 While rst is high at a clk edge, the block SHALL set S1.valid=0, S2.valid=0, out_valid=0, inst=0, err=0 and err_cnt=0.
REQ-013 While rst is high, in_ready SHALL be 0.
REQ-014 Reset asserted mid-operation SHALL discard in-flight requests, which are never output.
REQ-015 On the first cycle after rst deasserts, in_ready SHALL be 1.

Structure
REQ-016 A shared package SHALL hold the mode encodings (MODE_R..MODE_ILL, identical to the immediate-decoder mode codes) and the opcode constants used by the bench.
REQ-017 Packing and range check SHALL live in one combinational sub-module, imm_pack (inputs: mode, imm and fields; outputs: inst, err), instantiated between S1 and S2.

Verification
REQ-018 The bench SHALL cover these directed scenarios (stimulus -> required response):
- I, imm=0xFFFFFFFF, opcode=0x13, funct3=0, rd=1, rs1=0 -> inst=0xFFF00093, err=0, out_valid two cycles after acceptance.
- U, imm=0x12345000, rd=5, opcode=0x37 -> inst=0x123452B7; then imm=0x12345001 -> err=1, err_cnt=1.
- J, imm=8, rd=1, opcode=0x6F -> inst=0x008000EF; B, imm=0xFFFFFFFC, rs1=rs2=0, funct3=0, opcode=0x63 -> inst=0xFE000EE3.
- out_ready=0 while 3 back-to-back requests are offered -> 2 accepted, in_ready=0; out_ready then raised -> outputs in original order, third accepted afterwards.
- I, imm=2048 -> err=1; mode=7 -> inst=0, err=1; err_cnt preloaded near max -> saturates at 0xFFFF.
- rst pulsed with both stages full -> out_valid=0 next cycle, err_cnt=0, no stale output after release.
